// File: rtl/debug_cmd_decoder.sv
// Debug command decoder: turns debug-UART receive bytes into CPU debug control and instruction-memory writes.
// Latency: every pulse / write strobe / reply is registered and appears 1 cycle after the rx_valid of its completing byte.
// Backpressure: none on rx; one-deep tx reply held until tx_ready, a PING arriving while a reply is pending is dropped with cmd_error.
// Optional DEBUG_CMD_TIMEOUT_EN: abandons a stalled multi-byte command after TIMEOUT_CYC idle cycles.
module debug_cmd_decoder #(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              pause_pulse,
    output logic              resume_pulse,
    output logic              next_pulse,
    output logic [31:0]       bp_addr,
    output logic              prog_busy,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [31:0]       prog_wdata,
    output logic              cmd_error
);

    localparam logic [7:0] OP_PING    = 8'h03;
    localparam logic [7:0] OP_PAUSE   = 8'h04;
    localparam logic [7:0] OP_RESUME  = 8'h05;
    localparam logic [7:0] OP_NEXT    = 8'h06;
    localparam logic [7:0] OP_PROGRAM = 8'h07;
    localparam logic [7:0] OP_FILLER  = 8'hFF;
    localparam logic [7:0] PING_REPLY = 8'h02;

    typedef enum logic [1:0] {
        IDLE,
        BP_BYTES,
        LEN_BYTES,
        DATA_BYTES
    } state_t;

    state_t            state;
    logic [1:0]        byte_cnt;
    logic [31:0]       shadow;
    logic [31:0]       words_left;
    logic [ADDR_W-1:0] word_idx;
    // Set with the final write strobe so prog_busy falls one cycle after it.
    logic              last_word;
    // Little-endian assembly: bytes shift in from the top, so after four bytes the word is complete.
    logic [31:0]       word_full;

`ifdef DEBUG_CMD_TIMEOUT_EN
    logic [31:0]       to_cnt;
`endif

    assign word_full = {rx_data, shadow[31:8]};

    // Command FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            byte_cnt     <= 2'd0;
            shadow       <= 32'd0;
            words_left   <= 32'd0;
            word_idx     <= '0;
            last_word    <= 1'b0;
            tx_data      <= 8'd0;
            tx_valid     <= 1'b0;
            pause_pulse  <= 1'b0;
            resume_pulse <= 1'b0;
            next_pulse   <= 1'b0;
            bp_addr      <= 32'd0;
            prog_busy    <= 1'b0;
            prog_we      <= 1'b0;
            prog_addr    <= '0;
            prog_wdata   <= 32'd0;
            cmd_error    <= 1'b0;
`ifdef DEBUG_CMD_TIMEOUT_EN
            to_cnt       <= 32'd0;
`endif
        end else begin
            pause_pulse  <= 1'b0;
            resume_pulse <= 1'b0;
            next_pulse   <= 1'b0;
            prog_we      <= 1'b0;
            cmd_error    <= 1'b0;

            if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end

            // A new PROGRAM opcode decoded below in this same cycle overrides this drop.
            if (last_word) begin
                prog_busy <= 1'b0;
                last_word <= 1'b0;
            end

            if (rx_valid) begin
                case (state)
                    IDLE: begin
                        case (rx_data)
                            OP_PING: begin
                                if (tx_valid) begin
                                    cmd_error <= 1'b1;
                                end else begin
                                    tx_valid <= 1'b1;
                                    tx_data  <= PING_REPLY;
                                end
                            end
                            OP_PAUSE:  pause_pulse <= 1'b1;
                            OP_NEXT:   next_pulse  <= 1'b1;
                            OP_RESUME: begin
                                state    <= BP_BYTES;
                                byte_cnt <= 2'd0;
                            end
                            OP_PROGRAM: begin
                                state     <= LEN_BYTES;
                                byte_cnt  <= 2'd0;
                                word_idx  <= '0;
                                prog_busy <= 1'b1;
                            end
                            OP_FILLER: ;
                            default:   cmd_error <= 1'b1;
                        endcase
                    end
                    BP_BYTES: begin
                        shadow   <= word_full;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            bp_addr      <= word_full;
                            resume_pulse <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                    LEN_BYTES: begin
                        shadow   <= word_full;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            words_left <= word_full;
                            if (word_full == 32'd0) begin
                                state     <= IDLE;
                                prog_busy <= 1'b0;
                            end else begin
                                state <= DATA_BYTES;
                            end
                        end
                    end
                    DATA_BYTES: begin
                        shadow   <= word_full;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            prog_we    <= 1'b1;
                            prog_wdata <= word_full;
                            // Word index is ADDR_W wide, so long transfers wrap to 0.
                            prog_addr  <= word_idx;
                            word_idx   <= word_idx + 1'b1;
                            words_left <= words_left - 32'd1;
                            if (words_left == 32'd1) begin
                                state     <= IDLE;
                                last_word <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

`ifdef DEBUG_CMD_TIMEOUT_EN
            // Inter-byte watchdog: only runs while a multi-byte command is open.
            if (rx_valid || state == IDLE) begin
                to_cnt <= 32'd0;
            end else if (to_cnt == 32'(TIMEOUT_CYC - 1)) begin
                to_cnt    <= 32'd0;
                state     <= IDLE;
                byte_cnt  <= 2'd0;
                cmd_error <= 1'b1;
                prog_busy <= 1'b0;
                last_word <= 1'b0;
            end else begin
                to_cnt <= to_cnt + 32'd1;
            end
`endif
        end
    end

endmodule
